// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I constants: ALU_Ctrl codes, base opcodes,
//               funct3/funct7 values and the encoder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // ALU_Ctrl codes, shared with the ALU control decoder
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_ADDI  = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_ORI   = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_XORI  = 5'd6;
    localparam logic [4:0] ALU_AND   = 5'd7;
    localparam logic [4:0] ALU_ANDI  = 5'd8;
    localparam logic [4:0] ALU_SUB   = 5'd9;
    localparam logic [4:0] ALU_SLT   = 5'd10;
    localparam logic [4:0] ALU_SLTI  = 5'd11;
    localparam logic [4:0] ALU_SLTU  = 5'd12;
    localparam logic [4:0] ALU_SLTIU = 5'd13;
    localparam logic [4:0] ALU_SLLI  = 5'd14;
    localparam logic [4:0] ALU_SRLI  = 5'd15;
    localparam logic [4:0] ALU_SRAI  = 5'd16;
    localparam logic [4:0] ALU_SLL   = 5'd17;
    localparam logic [4:0] ALU_SRL   = 5'd18;
    localparam logic [4:0] ALU_SRA   = 5'd19;

    // Base opcodes
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values (also imm[11:5] for immediate shifts)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // I-type ops whose funct3 is a shift carry a shamt plus a fixed imm[11:5]
    function automatic logic is_imm_shift(input logic is_rtype, input logic [2:0] funct3);
        return !is_rtype && ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_field_lut.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_field_lut
// Description : Combinational ALU_Ctrl -> {legal, is_rtype, funct3, funct7}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_field_lut
    import rv32i_pkg::*;
(
    input  logic [4:0] op,
    output logic       legal,
    output logic       is_rtype,
    output logic [2:0] funct3,
    output logic [6:0] funct7
);

    // Field table; unlisted codes fall through as illegal
    always_comb begin
        legal    = 1'b1;
        is_rtype = 1'b0;
        funct3   = F3_ADD_SUB;
        funct7   = F7_BASE;
        case (op)
            ALU_ADD:   begin is_rtype = 1'b1; funct3 = F3_ADD_SUB; end
            ALU_SUB:   begin is_rtype = 1'b1; funct3 = F3_ADD_SUB; funct7 = F7_ALT; end
            ALU_OR:    begin is_rtype = 1'b1; funct3 = F3_OR;      end
            ALU_XOR:   begin is_rtype = 1'b1; funct3 = F3_XOR;     end
            ALU_AND:   begin is_rtype = 1'b1; funct3 = F3_AND;     end
            ALU_SLT:   begin is_rtype = 1'b1; funct3 = F3_SLT;     end
            ALU_SLTU:  begin is_rtype = 1'b1; funct3 = F3_SLTU;    end
            ALU_SLL:   begin is_rtype = 1'b1; funct3 = F3_SLL;     end
            ALU_SRL:   begin is_rtype = 1'b1; funct3 = F3_SRL_SRA; end
            ALU_SRA:   begin is_rtype = 1'b1; funct3 = F3_SRL_SRA; funct7 = F7_ALT; end
            ALU_ADDI:  funct3 = F3_ADD_SUB;
            ALU_ORI:   funct3 = F3_OR;
            ALU_XORI:  funct3 = F3_XOR;
            ALU_ANDI:  funct3 = F3_AND;
            ALU_SLTI:  funct3 = F3_SLT;
            ALU_SLTIU: funct3 = F3_SLTU;
            ALU_SLLI:  funct3 = F3_SLL;
            ALU_SRLI:  funct3 = F3_SRL_SRA;
            ALU_SRAI:  begin funct3 = F3_SRL_SRA; funct7 = F7_ALT; end
            default:   legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_encoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_encoder
// Description : Encodes ALU_Ctrl requests into RV32I R/I-type words and
//               streams them into instruction memory from a base address.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [11:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  c_last_word = CNT_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_rem;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_legal;
    logic              w_is_rtype;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [31:0]       w_word;

    alu_op_field_lut u_lut (
        .op       (req_op),
        .legal    (w_legal),
        .is_rtype (w_is_rtype),
        .funct3   (w_funct3),
        .funct7   (w_funct7)
    );

    // Assemble the instruction word from the looked-up fields and request
    always_comb begin
        w_word = {req_imm, req_rs1, w_funct3, req_rd, OP_ITYPE};
        if (w_is_rtype) begin
            w_word = {w_funct7, req_rs2, req_rs1, w_funct3, req_rd, OP_RTYPE};
        end else if (is_imm_shift(w_is_rtype, w_funct3)) begin
            w_word = {w_funct7, req_imm[4:0], req_rs1, w_funct3, req_rd, OP_ITYPE};
        end
    end

    // FSM, pointer/count and registered write port; illegal ops consume the
    // request but leave the write port, pointer and count untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_ptr   <= {base_addr[ADDR_W-1:2], 2'b00};
                        r_rem   <= word_count;
                        r_err   <= 1'b0;
                        r_state <= (word_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_wdata <= w_word;
                            r_ptr   <= r_ptr + c_addr_step;
                            r_rem   <= r_rem - c_last_word;
                            if (r_rem == c_last_word) begin
                                r_state <= DONE;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == RUN);
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign err_illegal = r_err;

endmodule
`default_nettype wire

// File: doc/alu_op_encoder.md
Name: alu_op_encoder

Overview:
- Encoder counterpart to the RV32I ALU control decoder: takes an ALU_Ctrl code plus register and immediate fields, and produces the 32-bit RV32I R-/I-type instruction word.
- Streams the encoded words into instruction memory through a write port, from a base address, for a programmed word count.
- Used by bring-up and self-test to generate instruction images on-chip.

Parameters:
- ADDR_W, 10, byte-address width of the instruction memory write port.
- CNT_W, 8, width of the word-count register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; loads base_addr and word_count. Honoured only in IDLE or DONE.
- base_addr  in  ADDR_W  first byte address; bits [1:0] are ignored and forced to 0.
- word_count  in  CNT_W  number of words to write; 0 means go straight to DONE.
- req_valid  in  1  an encode request is present.
- req_ready  out  1  the block accepts a request this cycle.
- req_op  in  5  ALU_Ctrl code.
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2 (R-type only).
- req_imm  in  12  I-type immediate; for shifts only [4:0] is used.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the word being written.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high while in RUN.
- done  out  1  level, high in DONE until the next start.
- err_illegal  out  1  sticky flag: an illegal op was accepted; cleared by start.

Behaviour:
- Reset: every output is 0, state is IDLE, address pointer is 0, remaining count is 0.
- FSM states:
  - IDLE: start → RUN, or → DONE if word_count is 0.
  - RUN: a legal accept while remaining is 1 → DONE.
  - DONE: start behaves as in IDLE.
  - start in RUN is ignored.
- Handshake:
  - req_ready = (state == RUN), combinational from state only.
  - A transfer happens on a rising edge with req_valid && req_ready.
  - req_valid may be held with no ready; fields must stay stable until the transfer.
- Latency and throughput:
  - A transfer at edge N drives imem_we/imem_addr/imem_wdata registered during cycle N+1.
  - Throughput is 1 word per cycle.
  - The final accept moves the FSM to DONE at the same edge, so req_ready is low in cycle N+1 while the last write is still presented.
- Pointer and count:
  - Each legal transfer writes at the current pointer, then pointer += 4 modulo 2^ADDR_W (wrap, no error).
  - remaining decrements by 1 per legal transfer.
- Encoding; R-type word = funct7|rs2|rs1|funct3|rd|opcode; I-type word = imm|rs1|funct3|rd|opcode:
  - R-type, opcode 0110011:
    - 1 ADD f3=000 f7=0000000
    - 9 SUB f3=000 f7=0100000
    - 3 OR 110
    - 5 XOR 100
    - 7 AND 111
    - 10 SLT 010
    - 12 SLTU 011
    - 17 SLL 001
    - 18 SRL 101
    - 19 SRA 101 with f7=0100000
    - All others use f7=0000000.
  - I-type, opcode 0010011:
    - 2 ADDI 000
    - 4 ORI 110
    - 6 XORI 100
    - 8 ANDI 111
    - 11 SLTI 010
    - 13 SLTIU 011
  - Shifts, opcode 0010011, imm[11:5] forced (req_imm[11:5] ignored), shamt = req_imm[4:0]:
    - 14 SLLI f3=001, imm[11:5]=0000000
    - 15 SRLI f3=101, imm[11:5]=0000000
    - 16 SRAI f3=101, imm[11:5]=0100000
  - Field placement must be bit-exact to the RV32I base ISA.
- Illegal op (0 or 20..31):
  - The transfer completes, but there is no write and no pointer/count change.
  - err_illegal is set, and is sticky.
- Outputs when not writing:
  - imem_we is 0.
  - imem_wdata and imem_addr hold their last values.
- Reset asserted mid-run: immediate return to the reset state; any in-flight write is dropped (imem_we low asynchronously).

Decomposition:
- Shared package rv32i_pkg, containing:
  - ALU_Ctrl code constants (1..19), shared with the decoder.
  - Opcode constants OP_RTYPE=0110011 and OP_ITYPE=0010011.
  - funct3 constants, and the funct7 constants F7_BASE and F7_ALT.
  - FSM state typedef (IDLE, RUN, DONE).
- One natural sub-module: alu_op_field_lut, a combinational op → {legal, is_rtype, funct3, funct7} table.
- The top level holds the FSM, the pointer/count, and the output registers.

Test Plan:
- All-ops sweep:
  - Stimulus: start base=0x100, count=19; ops 1..19 back-to-back, rd=1, rs1=2, rs2=3, imm=0x005.
  - Expected:
    - 19 consecutive imem_we at 0x100..0x148.
    - ADD=0x003100B3, SUB=0x403100B3, ADDI=0x00510093, SRAI=0x40515093.
    - done rises in the cycle after the last transfer.
- Backpressure/latency:
  - Stimulus: req_valid pulsed with gaps.
  - Expected: each imem_we occurs exactly 1 cycle after its transfer; no writes in gap cycles.
- Illegal op:
  - Stimulus: count=2; ops 1, 25, 3.
  - Expected: err_illegal sets after op 25; only 2 writes, at base and base+4; DONE after op 3.
- Wrap and count:
  - Stimulus: ADDR_W=10, base=0x3FC, count=2.
  - Expected: writes at 0x3FC then 0x000; start with word_count=0 → DONE next cycle with no writes.
- Reset and start rules:
  - Stimulus: rst_n low for 1 cycle mid-RUN; start pulsed during RUN.
  - Expected:
    - Reset: all outputs 0 and state IDLE immediately.
    - Start in RUN: ignored, pointer and count unchanged.
